// File: rtl/ctrl_pipe_stage.sv
// Control-bundle pipeline for the EX/MEM/WB stages. It detects load-use hazards
// (stall) and taken-branch squashes (flush). Define CTRL_PIPE_PERF_EN to add the
// stall/flush performance counters.
module ctrl_pipe_stage #(
  parameter int REG_W  = 5,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [REG_W-1:0]  id_rs1,
  input  logic [REG_W-1:0]  id_rs2,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              ex_br_taken,
  output logic              stall,
  output logic              flush,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [REG_W-1:0]  ex_rd,
  output logic              mem_valid,
  output logic [CTRL_W-1:0] mem_ctrl,
  output logic [REG_W-1:0]  mem_rd,
  output logic              wb_valid,
  output logic [CTRL_W-1:0] wb_ctrl,
  output logic [REG_W-1:0]  wb_rd
`ifdef CTRL_PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  logic              ex_valid_q,  ex_valid_d;
  logic [CTRL_W-1:0] ex_ctrl_q,   ex_ctrl_d;
  logic [REG_W-1:0]  ex_rd_q,     ex_rd_d;
  logic              mem_valid_q, mem_valid_d;
  logic [CTRL_W-1:0] mem_ctrl_q,  mem_ctrl_d;
  logic [REG_W-1:0]  mem_rd_q,    mem_rd_d;
  logic              wb_valid_q,  wb_valid_d;
  logic [CTRL_W-1:0] wb_ctrl_q,   wb_ctrl_d;
  logic [REG_W-1:0]  wb_rd_q,     wb_rd_d;

  logic uses_rs2_s;
  logic hazard_s;
  logic flush_s;

  // Hazard detection; a taken branch wins over a load-use stall.
  always_comb begin
    uses_rs2_s = (id_ctrl[7] == 1'b0) | id_ctrl[3];
    hazard_s   = id_valid & ex_valid_q & ex_ctrl_q[4] &
                 (ex_rd_q != {REG_W{1'b0}}) &
                 ((ex_rd_q == id_rs1) | (uses_rs2_s & (ex_rd_q == id_rs2)));
    flush_s    = ex_valid_q & ex_ctrl_q[0] & ex_br_taken;
  end

  assign stall = hazard_s & ~flush_s;
  assign flush = flush_s;

  // Next-state for the three stage registers.
  always_comb begin
    ex_valid_d = 1'b0;
    ex_ctrl_d  = {CTRL_W{1'b0}};
    ex_rd_d    = {REG_W{1'b0}};
    if (id_valid && !flush_s && !hazard_s) begin
      ex_valid_d = 1'b1;
      ex_ctrl_d  = id_ctrl;
      ex_rd_d    = id_rd;
    end else begin
      ex_valid_d = 1'b0;
      ex_ctrl_d  = {CTRL_W{1'b0}};
      ex_rd_d    = {REG_W{1'b0}};
    end
    mem_valid_d = ex_valid_q;
    mem_ctrl_d  = ex_ctrl_q;
    mem_rd_d    = ex_rd_q;
    wb_valid_d  = mem_valid_q;
    wb_ctrl_d   = mem_ctrl_q;
    wb_rd_d     = mem_rd_q;
  end

  // Stage registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q  <= 1'b0;
      ex_ctrl_q   <= {CTRL_W{1'b0}};
      ex_rd_q     <= {REG_W{1'b0}};
      mem_valid_q <= 1'b0;
      mem_ctrl_q  <= {CTRL_W{1'b0}};
      mem_rd_q    <= {REG_W{1'b0}};
      wb_valid_q  <= 1'b0;
      wb_ctrl_q   <= {CTRL_W{1'b0}};
      wb_rd_q     <= {REG_W{1'b0}};
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_ctrl_q   <= ex_ctrl_d;
      ex_rd_q     <= ex_rd_d;
      mem_valid_q <= mem_valid_d;
      mem_ctrl_q  <= mem_ctrl_d;
      mem_rd_q    <= mem_rd_d;
      wb_valid_q  <= wb_valid_d;
      wb_ctrl_q   <= wb_ctrl_d;
      wb_rd_q     <= wb_rd_d;
    end
  end

  assign ex_valid  = ex_valid_q;
  assign ex_ctrl   = ex_ctrl_q;
  assign ex_rd     = ex_rd_q;
  assign mem_valid = mem_valid_q;
  assign mem_ctrl  = mem_ctrl_q;
  assign mem_rd    = mem_rd_q;
  assign wb_valid  = wb_valid_q;
  assign wb_ctrl   = wb_ctrl_q;
  assign wb_rd     = wb_rd_q;

`ifdef CTRL_PIPE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  // Keeps CNT_W referenced when the counters are compiled out.
  logic [CNT_W-1:0] unused_cnt_s;
  assign unused_cnt_s = {CNT_W{1'b0}};
`endif

endmodule
